// File: rtl/lsu_pipe.sv
// ---------------------------------------------------------------------------
// lsu_pipe -- handshaked load/store unit for a synchronous data RAM plus a
// small memory-mapped I/O block (LEDR, LEDG, HEX0..HEX(NUM_HEX-1), LCD, SW).
//
// Handshake: a request is accepted at a rising clk_i edge when req_i and
// ready_o are both 1. ready_o is 1 only while the unit is idle. A request
// presented while ready_o=0 is ignored, not queued. Stores commit at the
// accept edge and keep the unit idle, so one store per cycle is possible.
// Loads take the path IDLE -> RD -> RESP. ld_valid_o is high for the single
// RESP cycle, and ld_data_o holds its value between responses.
//
// Memory map (byte addresses):
//   0x0000_0000 .. 4*DMEM_DEPTH-1   data RAM
//   0x7000 LEDR, 0x7010 LEDG, 0x7020+4i HEXi, 0x7040 LCD, 0x7800 SW (RO)
//   Any other address is unmapped. Stores to it are dropped, and loads
//   from it return 0.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i, we_i            request, 1 = store / 0 = load
//   addr_i, st_data_i      byte address, right-aligned store data
//   loadsave_op_i          funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//                          (011, 110 and 111 behave as W)
//   ready_o                unit can accept a request this cycle
//   ld_valid_o, ld_data_o  load response pulse and extended load data
//   misalign_o             one-cycle pulse after a misaligned accept
//   io_sw_i                switch inputs
//   io_ledr_o, io_ledg_o   LED registers
//   io_lcd_o               LCD register
//   io_hex_o               HEX registers, channel i at [32i+31:32i]
//   state_o                current FSM state (debug visibility)
//
// Optional feature: define LSU_SW_SYNC_EN to pass io_sw_i through a
// two-flop synchroniser before loads read it.
// ---------------------------------------------------------------------------
module lsu_pipe #(
    parameter int DMEM_DEPTH = 2048,
    parameter int NUM_HEX    = 8,
    parameter int SW_W       = 32,
    parameter int LED_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           st_data_i,
    input  logic [2:0]            loadsave_op_i,
    output logic                  ready_o,
    output logic                  ld_valid_o,
    output logic [31:0]           ld_data_o,
    output logic                  misalign_o,
    input  logic [SW_W-1:0]       io_sw_i,
    output logic [LED_W-1:0]      io_ledr_o,
    output logic [LED_W-1:0]      io_ledg_o,
    output logic [31:0]           io_lcd_o,
    output logic [NUM_HEX*32-1:0] io_hex_o,
    output logic [1:0]            state_o
);

    localparam int AW = $clog2(DMEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Merge new data into an old word under a byte-lane mask.
    function automatic logic [31:0] merge32(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Request-side decode
    // ------------------------------------------------------------------
    logic        accept, st_fire, ld_fire, mis_in;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        w_dmem, w_ledr, w_ledg, w_lcd, w_hex;

    assign accept  = req_i & ready_o;
    assign st_fire = accept & we_i & ~mis_in;
    assign ld_fire = accept & ~we_i;

    // Word-level decodes compare the word address (addr[31:2]).
    assign w_dmem = (addr_i[31:AW+2] == '0);
    assign w_ledr = (addr_i[31:2] == 30'h1C00);
    assign w_ledg = (addr_i[31:2] == 30'h1C04);
    assign w_lcd  = (addr_i[31:2] == 30'h1C10);
    // HEX block spans 0x7020..0x703F, only the first NUM_HEX words exist.
    assign w_hex  = (addr_i[31:5] == 27'h381) && ({29'd0, addr_i[4:2]} < NUM_HEX);

    // Access size comes from op[1:0]; op[2] only selects zero-extension.
    always_comb begin
        mis_in = 1'b0;
        wmask  = 4'b1111;
        wdata  = st_data_i;
        case (loadsave_op_i[1:0])
            2'b00: begin
                mis_in = 1'b0;
                wmask  = 4'b0001 << addr_i[1:0];
                wdata  = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                mis_in = addr_i[0];
                wmask  = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata  = {2{st_data_i[15:0]}};
            end
            default: begin
                mis_in = (addr_i[1:0] != 2'b00);
                wmask  = 4'b1111;
                wdata  = st_data_i;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ready_o    = 1'b0;
        ld_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (req_i && !we_i) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                ld_valid_o = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state_o = state_q;

    // ------------------------------------------------------------------
    // Data RAM: byte-lane writes at accept, synchronous read at load accept
    // ------------------------------------------------------------------
    logic [31:0] mem [DMEM_DEPTH];
    logic [31:0] mem_rdata;

    always_ff @(posedge clk_i) begin
        if (st_fire && w_dmem) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    mem[addr_i[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (ld_fire) begin
            mem_rdata <= mem[addr_i[AW+1:2]];
        end
    end

    // ------------------------------------------------------------------
    // I/O registers
    // ------------------------------------------------------------------
    logic [LED_W-1:0] ledr_q, ledg_q;
    logic [31:0]      lcd_q;
    logic [31:0]      hex_q [NUM_HEX];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ledr_q <= '0;
            ledg_q <= '0;
            lcd_q  <= '0;
            for (int i = 0; i < NUM_HEX; i++) begin
                hex_q[i] <= '0;
            end
        end else if (st_fire) begin
            if (w_ledr) ledr_q <= LED_W'(merge32(32'(ledr_q), wdata, wmask));
            if (w_ledg) ledg_q <= LED_W'(merge32(32'(ledg_q), wdata, wmask));
            if (w_lcd)  lcd_q  <= merge32(lcd_q, wdata, wmask);
            for (int i = 0; i < NUM_HEX; i++) begin
                if (w_hex && addr_i[4:2] == 3'(i)) begin
                    hex_q[i] <= merge32(hex_q[i], wdata, wmask);
                end
            end
        end
    end

    assign io_ledr_o = ledr_q;
    assign io_ledg_o = ledg_q;
    assign io_lcd_o  = lcd_q;

    for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
        assign io_hex_o[32*g +: 32] = hex_q[g];
    end

    // ------------------------------------------------------------------
    // Switch input path
    // ------------------------------------------------------------------
    logic [SW_W-1:0] sw_rd;

`ifdef LSU_SW_SYNC_EN
    logic [SW_W-1:0] sw_meta_q, sw_sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= io_sw_i;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign sw_rd = sw_sync_q;
`else
    assign sw_rd = io_sw_i;
`endif

    // ------------------------------------------------------------------
    // Load path: request registered at accept, result registered in RD
    // ------------------------------------------------------------------
    logic [31:0] l_addr_q;
    logic [2:0]  l_op_q;
    logic        l_mis_q;
    logic [31:0] ld_data_q;
    logic        misalign_q;
    logic        r_dmem, r_ledr, r_ledg, r_lcd, r_hex, r_sw;
    logic [31:0] rd_word, ld_ext;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign r_dmem = (l_addr_q[31:AW+2] == '0);
    assign r_ledr = (l_addr_q[31:2] == 30'h1C00);
    assign r_ledg = (l_addr_q[31:2] == 30'h1C04);
    assign r_lcd  = (l_addr_q[31:2] == 30'h1C10);
    assign r_sw   = (l_addr_q[31:2] == 30'h1E00);
    assign r_hex  = (l_addr_q[31:5] == 27'h381) && ({29'd0, l_addr_q[4:2]} < NUM_HEX);

    // Regions are disjoint, so the independent ifs never overlap.
    // A misaligned load reads as 0.
    always_comb begin
        rd_word = '0;
        if (!l_mis_q) begin
            if (r_dmem) rd_word = mem_rdata;
            if (r_ledr) rd_word = 32'(ledr_q);
            if (r_ledg) rd_word = 32'(ledg_q);
            if (r_lcd)  rd_word = lcd_q;
            if (r_sw)   rd_word = 32'(sw_rd);
            for (int i = 0; i < NUM_HEX; i++) begin
                if (r_hex && l_addr_q[4:2] == 3'(i)) begin
                    rd_word = hex_q[i];
                end
            end
        end
    end

    always_comb begin
        rd_byte = rd_word[7:0];
        case (l_addr_q[1:0])
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = l_addr_q[1] ? rd_word[31:16] : rd_word[15:0];

        case (l_op_q)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_ext = {24'd0, rd_byte};
            3'b101:  ld_ext = {16'd0, rd_half};
            default: ld_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            l_addr_q   <= '0;
            l_op_q     <= '0;
            l_mis_q    <= 1'b0;
            ld_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept & mis_in;
            if (ld_fire) begin
                l_addr_q <= addr_i;
                l_op_q   <= loadsave_op_i;
                l_mis_q  <= mis_in;
            end
            if (state_q == S_RD) begin
                ld_data_q <= ld_ext;
            end
        end
    end

    assign ld_data_o  = ld_data_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_lsu_pipe.sv
module tb_lsu_pipe;
  localparam int DMEM_DEPTH = 2048;
  localparam int NUM_HEX    = 8;
  localparam int SW_W       = 32;
  localparam int LED_W      = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  req, we;
  logic [31:0]           addr, st_data;
  logic [2:0]            op;
  logic                  ready, ld_valid, misalign;
  logic [31:0]           ld_data;
  logic [SW_W-1:0]       io_sw;
  logic [LED_W-1:0]      ledr, ledg;
  logic [31:0]           lcd;
  logic [NUM_HEX*32-1:0] hex;
  logic [1:0]            dbg_state;

  lsu_pipe #(
    .DMEM_DEPTH(DMEM_DEPTH), .NUM_HEX(NUM_HEX), .SW_W(SW_W), .LED_W(LED_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .st_data_i(st_data), .loadsave_op_i(op), .ready_o(ready),
    .ld_valid_o(ld_valid), .ld_data_o(ld_data), .misalign_o(misalign),
    .io_sw_i(io_sw), .io_ledr_o(ledr), .io_ledg_o(ledg), .io_lcd_o(lcd),
    .io_hex_o(hex), .state_o(dbg_state)
  );

  int total = 0;
  int bad = 0;

  // ---------------- reference model ----------------
  logic [7:0]  mem_m [logic [31:0]];
  logic [31:0] io_m  [logic [31:0]];

  function automatic int unsigned op_size(input logic [2:0] o);
    case (o[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [2:0] o);
    return (a % op_size(o)) != 0;
  endfunction

  function automatic bit is_io_reg(input logic [31:0] w);
    return (w == 32'h7000) || (w == 32'h7010) || (w == 32'h7040) ||
           (w >= 32'h7020 && w < 32'h7020 + 4 * NUM_HEX);
  endfunction

  function automatic void reset_io_model();
    io_m[32'h7000] = 0;
    io_m[32'h7010] = 0;
    io_m[32'h7040] = 0;
    for (int i = 0; i < NUM_HEX; i++) io_m[32'h7020 + 4 * i] = 0;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    logic [31:0] w = {a[31:2], 2'b00};
    logic [31:0] word;
    if (a < 4 * DMEM_DEPTH) return mem_m.exists(a) ? mem_m[a] : 8'h00;
    if (is_io_reg(w)) word = io_m[w];
    else if (w == 32'h7800) word = io_sw;
    else word = 0;
    return word[8 * a[1:0] +: 8];
  endfunction

  function automatic void put_byte(input logic [31:0] a, input logic [7:0] b);
    logic [31:0] w = {a[31:2], 2'b00};
    logic [31:0] tmp;
    if (a < 4 * DMEM_DEPTH) begin
      mem_m[a] = b;
    end else if (is_io_reg(w)) begin
      tmp = io_m[w];
      tmp[8 * a[1:0] +: 8] = b;
      io_m[w] = tmp;
    end
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                      input logic [2:0] o);
    int unsigned sz = op_size(o);
    logic [31:0] base;
    if (is_mis(a, o)) return;
    base = a - (a % sz);
    for (int k = 0; k < sz; k++) put_byte(base + k, d[8 * k +: 8]);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] o);
    int unsigned sz = op_size(o);
    logic [31:0] base;
    logic [31:0] v = 0;
    if (is_mis(a, o)) return 0;
    base = a - (a % sz);
    for (int k = 0; k < sz; k++) v[8 * k +: 8] = get_byte(base + k);
    if (!o[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
    else if (!o[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // ---------------- driver tasks (start and end at a negedge) ----------------
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] o);
    bit m = is_mis(a, o);
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL store_ready: got %b want 1", ready); end
    req = 1; we = 1; addr = a; st_data = d; op = o;
    @(negedge clk);
    req = 0; we = 0;
    model_store(a, d, o);
    total++;
    if (misalign !== m) begin
      bad++; $display("FAIL store_misalign @%h: got %b want %b", a, misalign, m);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] o);
    logic [31:0] exp = model_load(a, o);
    bit m = is_mis(a, o);
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL load_ready: got %b want 1", ready); end
    req = 1; we = 0; addr = a; op = o;
    @(negedge clk);
    req = 0;
    total++;
    if (misalign !== m || ready !== 1'b0 || ld_valid !== 1'b0) begin
      bad++;
      $display("FAIL load_c1 @%h: got mis=%b rdy=%b vld=%b want mis=%b rdy=0 vld=0",
               a, misalign, ready, ld_valid, m);
    end
    @(negedge clk);
    total++;
    if (ld_valid !== 1'b1 || ld_data !== exp || ready !== 1'b0 || misalign !== 1'b0) begin
      bad++;
      $display("FAIL load_c2 @%h op=%b: got vld=%b data=%h rdy=%b mis=%b want vld=1 data=%h rdy=0 mis=0",
               a, o, ld_valid, ld_data, ready, misalign, exp);
    end
    @(negedge clk);
    total++;
    if (ld_valid !== 1'b0 || ready !== 1'b1 || ld_data !== exp) begin
      bad++;
      $display("FAIL load_c3 @%h: got vld=%b rdy=%b data=%h want vld=0 rdy=1 data=%h",
               a, ld_valid, ready, ld_data, exp);
    end
  endtask

  task automatic check_io(input string tag);
    logic [NUM_HEX*32-1:0] hx;
    for (int i = 0; i < NUM_HEX; i++) hx[32 * i +: 32] = io_m[32'h7020 + 4 * i];
    total++;
    if (ledr !== io_m[32'h7000]) begin
      bad++; $display("FAIL %s ledr: got %h want %h", tag, ledr, io_m[32'h7000]);
    end
    total++;
    if (ledg !== io_m[32'h7010]) begin
      bad++; $display("FAIL %s ledg: got %h want %h", tag, ledg, io_m[32'h7010]);
    end
    total++;
    if (lcd !== io_m[32'h7040]) begin
      bad++; $display("FAIL %s lcd: got %h want %h", tag, lcd, io_m[32'h7040]);
    end
    total++;
    if (hex !== hx) begin
      bad++; $display("FAIL %s hex: got %h want %h", tag, hex, hx);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; req = 0; we = 0; addr = 0; st_data = 0; op = 0; io_sw = 0;
    reset_io_model();
    repeat (2) @(negedge clk);
    total++;
    if (ld_valid !== 1'b0 || ld_data !== 32'h0 || misalign !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got vld=%b data=%h mis=%b want 0 0 0", ld_valid, ld_data, misalign);
    end
    check_io("reset");
    rst_n = 1;
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || ld_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release: got rdy=%b vld=%b want 1 0", ready, ld_valid);
    end
  endtask

  task automatic test_init_mem();
    for (int w = 0; w < 32'h200; w += 4) do_store(w, 32'h0, 3'b010);
  endtask

  task automatic test_word();
    do_store(32'h100, 32'hDEADBEEF, 3'b010);
    do_load(32'h100, 3'b010);
  endtask

  task automatic test_byte();
    do_store(32'h101, 32'h00000080, 3'b000);
    do_load(32'h101, 3'b000);
    do_load(32'h101, 3'b100);
    do_load(32'h100, 3'b010);
    do_store(32'h106, 32'h0000F00D, 3'b001);
    do_load(32'h106, 3'b001);
    do_load(32'h106, 3'b101);
  endtask

  task automatic test_io();
    do_store(32'h702C, 32'h12345678, 3'b010);
    total++;
    if (hex[127:96] !== 32'h12345678) begin
      bad++; $display("FAIL hex3: got %h want 12345678", hex[127:96]);
    end
    do_store(32'h7012, 32'h0000AAAA, 3'b001);
    total++;
    if (ledg !== 32'hAAAA0000) begin
      bad++; $display("FAIL ledg_sh: got %h want aaaa0000", ledg);
    end
    do_store(32'h7041, 32'h000000C3, 3'b000);
    check_io("io");
    do_load(32'h702C, 3'b010);
    do_load(32'h7013, 3'b000);
    do_load(32'h7040, 3'b010);
    do_load(32'h7044, 3'b010);
  endtask

  task automatic test_misalign();
    do_load(32'h103, 3'b001);
    do_load(32'h102, 3'b010);
    do_store(32'h7002, 32'hFFFFFFFF, 3'b010);
    do_store(32'h105, 32'hFFFFFFFF, 3'b101);
    check_io("misalign");
    do_load(32'h104, 3'b010);
  endtask

  task automatic test_back_to_back();
    do_store(32'h180, 32'h11, 3'b000);
    do_store(32'h181, 32'h22, 3'b000);
    do_store(32'h182, 32'h33, 3'b000);
    do_store(32'h183, 32'h44, 3'b000);
    do_load(32'h180, 3'b010);
    do_load(32'h182, 3'b101);
  endtask

  task automatic test_busy_ignored();
    logic [31:0] exp = model_load(32'h1C0, 3'b010);
    req = 1; we = 0; addr = 32'h1C0; op = 3'b010;
    @(negedge clk);
    req = 1; we = 1; addr = 32'h1C0; st_data = 32'hFFFFFFFF; op = 3'b010;
    @(negedge clk);
    total++;
    if (ld_valid !== 1'b1 || ld_data !== exp || ready !== 1'b0) begin
      bad++;
      $display("FAIL busy_resp: got vld=%b data=%h rdy=%b want 1 %h 0", ld_valid, ld_data, ready, exp);
    end
    @(negedge clk);
    req = 0; we = 0;
    total++;
    if (ready !== 1'b1 || ld_valid !== 1'b0) begin
      bad++; $display("FAIL busy_idle: got rdy=%b vld=%b want 1 0", ready, ld_valid);
    end
    do_load(32'h1C0, 3'b010);
  endtask

  task automatic test_sw();
    logic [31:0] exp;
    io_sw = 32'h5;
    repeat (3) @(negedge clk);
    do_load(32'h7800, 3'b010);
    do_load(32'h7800, 3'b100);
`ifdef LSU_SW_SYNC_EN
    exp = 32'h5;
`else
    exp = 32'h9;
`endif
    io_sw = 32'h9; req = 1; we = 0; addr = 32'h7800; op = 3'b010;
    @(negedge clk);
    req = 0;
    @(negedge clk);
    total++;
    if (ld_valid !== 1'b1 || ld_data !== exp) begin
      bad++; $display("FAIL sw_change: got vld=%b data=%h want 1 %h", ld_valid, ld_data, exp);
    end
    repeat (3) @(negedge clk);
    do_store(32'h7800, 32'h0, 3'b010);
    do_load(32'h7800, 3'b010);
  endtask

  task automatic test_reset_mid_load();
    do_store(32'h7000, 32'h00001234, 3'b010);
    do_load(32'h100, 3'b010);
    req = 1; we = 0; addr = 32'h100; op = 3'b010;
    @(negedge clk);
    req = 0;
    rst_n = 0;
    reset_io_model();
    #1;
    total++;
    if (ld_valid !== 1'b0 || ld_data !== 32'h0 || misalign !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: got vld=%b data=%h mis=%b want 0 0 0", ld_valid, ld_data, misalign);
    end
    check_io("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (ld_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_vld: got %b want 0", ld_valid); end
    end
    rst_n = 1;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (ld_valid !== 1'b0 || ready !== 1'b1) begin
        bad++; $display("FAIL rst_after: got vld=%b rdy=%b want 0 1", ld_valid, ready);
      end
    end
    do_load(32'h100, 3'b010);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return 32'($urandom_range(0, 32'h1FF));
      3:       return 32'h7000 + 32'($urandom_range(0, 32'h4F));
      4:       return 32'h7800 + 32'($urandom_range(0, 7));
      default: return 32'h2000 + 32'($urandom_range(0, 32'hFF));
    endcase
  endfunction

  task automatic test_random();
    logic [2:0] st_ops [4];
    st_ops[0] = 3'b000; st_ops[1] = 3'b001; st_ops[2] = 3'b010; st_ops[3] = 3'b011;
    for (int n = 0; n < 150; n++) begin
      if (n % 40 == 0) begin
        io_sw = $urandom;
        repeat (3) @(negedge clk);
      end
      if ($urandom_range(0, 1) == 1)
        do_store(rand_addr(), $urandom, st_ops[$urandom_range(0, 3)]);
      else
        do_load(rand_addr(), 3'($urandom_range(0, 7)));
    end
    check_io("random");
  endtask

  // ---------------- main ----------------
  initial begin
    test_reset();
    test_init_mem();
    test_word();
    test_byte();
    test_io();
    test_misalign();
    test_back_to_back();
    test_busy_ignored();
    test_sw();
    test_reset_mid_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lsu_pipe.md
Name: lsu_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle load/store unit, built for the multi-cycle and pipelined core generations.
- Serves byte, halfword and word loads and stores to a synchronous data RAM and a memory-mapped I/O block.
- The number of HEX channels, the RAM depth and the I/O widths are configurable.
- Adds request/ready flow control, registered load responses, misalignment detection and byte-lane masked I/O writes.

Parameters:
- DMEM_DEPTH, 2048, data RAM depth in 32-bit words; power of two, max 4096.
- NUM_HEX, 8, number of HEX output registers, 1..8.
- SW_W, 32, width of the switch input.
- LED_W, 32, width of the LEDR and LEDG registers.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  access request.
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  32  byte address.
- st_data_i  in  32  store data, right-aligned.
- loadsave_op_i  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ready_o  out  1  unit can accept a request this cycle.
- ld_valid_o  out  1  single-cycle pulse; ld_data_o is valid.
- ld_data_o  out  32  load result, sign- or zero-extended.
- misalign_o  out  1  single-cycle pulse; the last accepted access was misaligned.
- io_sw_i  in  SW_W  switch inputs.
- io_ledr_o  out  LED_W  red LED register.
- io_ledg_o  out  LED_W  green LED register.
- io_lcd_o  out  32  LCD register.
- io_hex_o  out  NUM_HEX*32  HEX registers, flattened; channel i is bits [32i+31:32i].

Behaviour:
- Memory map:
  - DMEM at 0x0000_0000 .. 4*DMEM_DEPTH-1.
  - LEDR at 0x7000, LEDG at 0x7010.
  - HEXi at 0x7020+4i.
  - LCD at 0x7040.
  - SW at 0x7800, read-only.
  - Any other address is unmapped.
- Reset (async, rst_ni=0):
  - FSM goes to IDLE.
  - All I/O registers, ld_data_o, ld_valid_o and misalign_o are cleared to 0.
  - DMEM contents are not reset.
  - ready_o=1 from the first edge after reset release.
- FSM states: IDLE, RD, RESP.
  - ready_o=1 only in IDLE.
  - Accept = req_i & ready_o at a rising edge.
- Store:
  - Accepted in IDLE; the write commits at the accept edge. FSM stays in IDLE, so throughput is one store per cycle.
  - SB writes the lane addr[1:0]; SH writes the lanes selected by addr[1]; SW writes all four lanes.
  - Byte-lane masking applies to both DMEM and the I/O registers.
  - Stores to SW or unmapped addresses are dropped silently.
- Load:
  - IDLE -> RD at accept; address and op are registered, DMEM is read synchronously.
  - RD -> RESP: the extended result is registered.
  - In RESP, ld_valid_o=1 for exactly one cycle, then back to IDLE.
  - Latency: ld_valid_o rises 2 cycles after the accept edge. Issue rate is one load per 3 cycles.
  - Reading an I/O register returns its current value.
  - SW reads return io_sw_i zero-extended, sampled in RD.
  - Unmapped loads return 0.
- Misaligned access: H with addr[0]=1, or W with addr[1:0]!=0.
  - No memory or I/O side effect.
  - misalign_o pulses 1 cycle after the accept edge.
  - A misaligned load still walks RD -> RESP and returns ld_data_o=0 with ld_valid_o.
- Extension:
  - B/H sign-extend from bit 7/15.
  - BU/HU zero-extend.
  - Ops 011, 110 and 111 are treated as W.
- ld_data_o holds its last value when ld_valid_o=0.
- req_i is ignored while ready_o=0, so requests are never queued.
- Reset asserted in RD or RESP: the pending load is abandoned and no ld_valid_o is produced.

Optional Feature:
- Macro LSU_SW_SYNC_EN.
- Defined: io_sw_i passes through a 2-flop synchroniser (reset to 0) before read access, so a switch change is visible to loads 2 cycles later.
- Undefined: io_sw_i is sampled directly in RD.

Test Plan:
- Reset release then SW of 0xDEADBEEF to 0x100, then LW from 0x100 -> ld_valid_o 2 cycles after accept with ld_data_o=0xDEADBEEF; ready_o=0 for exactly 2 cycles.
- SB of 0x80 to 0x101, then LB and LBU from 0x101 -> 0xFFFFFF80 and 0x00000080; LW from 0x100 -> 0xDEAD80EF.
- SW of 0x12345678 to HEX3 (0x702C) with NUM_HEX=8 -> io_hex_o[127:96]=0x12345678 the cycle after accept; other channels stay 0; SH of 0xAAAA to 0x7012 -> io_ledg_o=0xAAAA0000.
- LH from 0x103 -> misalign_o pulse 1 cycle after accept, ld_valid_o with 0; SW to 0x7002 -> io_ledr_o unchanged and misalign_o pulses.
- Issue LW, assert rst_ni=0 while in RD -> no ld_valid_o, all outputs 0, ready_o=1 after release.
- io_sw_i=0x5 then LW from 0x7800 -> 0x5; with LSU_SW_SYNC_EN, a switch change 1 cycle before accept returns the old value.
